// File: rtl/screen_sequencer_if.sv
// Bundles the raster position, control levels, mapper colours and pin-side outputs of the screen sequencer.
// Modport master drives the inputs (VGA controller, game logic and mappers); modport slave is the sequencer.
interface screen_sequencer_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       start_req;
    logic       game_over;
    logic [3:0] start_r, start_g, start_b;
    logic [3:0] game_r,  game_g,  game_b;
    logic [3:0] over_r,  over_g,  over_b;
    logic [3:0] red, green, blue;
    logic [1:0] screen_sel;
    logic       busy;

    modport master (
        output DrawX, DrawY, blank, start_req, game_over,
        output start_r, start_g, start_b,
        output game_r,  game_g,  game_b,
        output over_r,  over_g,  over_b,
        input  red, green, blue, screen_sel, busy
    );

    modport slave (
        input  DrawX, DrawY, blank, start_req, game_over,
        input  start_r, start_g, start_b,
        input  game_r,  game_g,  game_b,
        input  over_r,  over_g,  over_b,
        output red, green, blue, screen_sel, busy
    );
endinterface

// File: rtl/screen_sequencer.sv
// Selects start/game/over background and fades it out to black, swaps source on a frame tick, fades back in.
// Latency: mapper RGB to pins is 1 vga_clk (single registered scale/blank stage).
// Backpressure: none; start_req/game_over are levels sampled every cycle and dropped while a fade runs.
module screen_sequencer #(
    parameter int V_ACTIVE        = 480,
    parameter int FRAMES_PER_STEP = 2,
    parameter int FADE_STEP       = 2
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    screen_sequencer_if.slave  bus
);

    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_GAME   = 3'd1,
        S_OVER   = 3'd2,
        FADE_OUT = 3'd3,
        FADE_IN  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic [1:0]    r_target, w_target_nxt;
    logic [4:0]    r_level, w_level_nxt;
    logic [CW-1:0] r_frame_cnt;
    logic          r_cond_d;
    logic          r_frame_tick;
    logic [3:0]    r_red, r_green, r_blue;

    logic          w_cond;
    logic          w_fading;
    logic          w_step;
    logic [3:0]    w_src_r, w_src_g, w_src_b;

    assign w_cond   = (bus.DrawX == 10'd0) && (bus.DrawY == 10'(V_ACTIVE));
    assign w_fading = (r_state == FADE_OUT) || (r_state == FADE_IN);
    assign w_step   = w_fading && r_frame_tick && (r_frame_cnt == CW'(FRAMES_PER_STEP - 1));

    // Rising-edge detect so a held raster position yields a single tick per frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cond_d     <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_cond_d     <= w_cond;
            r_frame_tick <= w_cond && !r_cond_d;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_target_nxt = r_target;
        w_level_nxt  = r_level;
        case (r_state)
            S_START: begin
                if (bus.start_req) begin
                    w_state_nxt  = FADE_OUT;
                    w_target_nxt = 2'd1;
                end
            end
            S_GAME: begin
                if (bus.game_over) begin
                    w_state_nxt  = FADE_OUT;
                    w_target_nxt = 2'd2;
                end
            end
            S_OVER: begin
                if (bus.start_req) begin
                    w_state_nxt  = FADE_OUT;
                    w_target_nxt = 2'd0;
                end
            end
            FADE_OUT: begin
                // The swap waits one extra step at black so it always lands on a frame tick.
                if (w_step) begin
                    if (r_level == 5'd0) begin
                        w_sel_nxt   = r_target;
                        w_state_nxt = FADE_IN;
                    end else if (r_level <= 5'(FADE_STEP)) begin
                        w_level_nxt = 5'd0;
                    end else begin
                        w_level_nxt = r_level - 5'(FADE_STEP);
                    end
                end
            end
            FADE_IN: begin
                if (w_step) begin
                    if (r_level >= 5'(16 - FADE_STEP)) begin
                        w_level_nxt = 5'd16;
                        case (r_sel)
                            2'd0:    w_state_nxt = S_START;
                            2'd1:    w_state_nxt = S_GAME;
                            default: w_state_nxt = S_OVER;
                        endcase
                    end else begin
                        w_level_nxt = r_level + 5'(FADE_STEP);
                    end
                end
            end
            default: begin
                w_state_nxt = S_START;
                w_sel_nxt   = 2'd0;
                w_level_nxt = 5'd16;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_START;
            r_sel       <= 2'd0;
            r_target    <= 2'd0;
            r_level     <= 5'd16;
            r_frame_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_target <= w_target_nxt;
            r_level  <= w_level_nxt;
            if (w_state_nxt != r_state) begin
                r_frame_cnt <= '0;
            end else if (w_fading && r_frame_tick) begin
                if (r_frame_cnt == CW'(FRAMES_PER_STEP - 1)) begin
                    r_frame_cnt <= '0;
                end else begin
                    r_frame_cnt <= r_frame_cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_src_r = bus.start_r;
        w_src_g = bus.start_g;
        w_src_b = bus.start_b;
        case (r_sel)
            2'd1: begin
                w_src_r = bus.game_r;
                w_src_g = bus.game_g;
                w_src_b = bus.game_b;
            end
            2'd2: begin
                w_src_r = bus.over_r;
                w_src_g = bus.over_g;
                w_src_b = bus.over_b;
            end
            default: ;
        endcase
    end

    // Scale by level/16: 4x5-bit product, keep bits [7:4]; level 16 is an exact pass-through.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_red   <= 4'd0;
            r_green <= 4'd0;
            r_blue  <= 4'd0;
        end else if (bus.blank) begin
            r_red   <= 4'(({5'd0, w_src_r} * {4'd0, r_level}) >> 4);
            r_green <= 4'(({5'd0, w_src_g} * {4'd0, r_level}) >> 4);
            r_blue  <= 4'(({5'd0, w_src_b} * {4'd0, r_level}) >> 4);
        end else begin
            r_red   <= 4'd0;
            r_green <= 4'd0;
            r_blue  <= 4'd0;
        end
    end

    assign bus.red        = r_red;
    assign bus.green      = r_green;
    assign bus.blue       = r_blue;
    assign bus.screen_sel = r_sel;
    assign bus.busy       = w_fading;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: frames are synthesised as short raster bursts, one tick each.
module tb_screen_sequencer;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    int   n_ticks = 0;

    screen_sequencer_if vif ();

    screen_sequencer dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (vif)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: a single cycle at the tick position, then ordinary raster.
    task automatic frame();
        vif.DrawX = 10'd0;
        vif.DrawY = 10'd480;
        tick();
        vif.DrawX = 10'd1;
        vif.DrawY = 10'd0;
        tick();
        tick();
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.DrawX = 10'd1;
        vif.DrawY = 10'd0;
        vif.blank = 1'b1;
        vif.start_req = 1'b0;
        vif.game_over = 1'b0;
        vif.start_r = 4'hF; vif.start_g = 4'h8; vif.start_b = 4'h1;
        vif.game_r  = 4'hF; vif.game_g  = 4'h3; vif.game_b  = 4'hC;
        vif.over_r  = 4'h9; vif.over_g  = 4'h6; vif.over_b  = 4'hA;

        // Reset state
        tick();
        tick();
        chk("rst_red", 8'(vif.red), 8'h0);
        chk("rst_sel", 8'(vif.screen_sel), 8'h0);
        chk("rst_busy", 8'(vif.busy), 8'h0);
        reset_n = 1'b1;
        tick();
        chk("start_red", 8'(vif.red), 8'hF);
        chk("start_green", 8'(vif.green), 8'h8);
        chk("start_blue", 8'(vif.blue), 8'h1);

        // Start -> game fade
        vif.start_req = 1'b1;
        tick();
        vif.start_req = 1'b0;
        chk("fo_busy", 8'(vif.busy), 8'h1);
        frame();
        chk("fo_1tick_red", 8'(vif.red), 8'hF);
        frame();
        chk("fo_l14_red", 8'(vif.red), 8'hD);
        chk("fo_l14_green", 8'(vif.green), 8'h7);
        frames(14);
        chk("fo_l0_red", 8'(vif.red), 8'h0);
        chk("fo_l0_sel", 8'(vif.screen_sel), 8'h0);
        frames(2);
        chk("swap_sel", 8'(vif.screen_sel), 8'h1);
        chk("swap_busy", 8'(vif.busy), 8'h1);
        chk("swap_red", 8'(vif.red), 8'h0);
        frames(8);
        chk("fi_l8_red", 8'(vif.red), 8'h7);
        vif.blank = 1'b0;
        tick();
        chk("blank_red", 8'(vif.red), 8'h0);
        vif.blank = 1'b1;
        frames(8);
        chk("game_busy", 8'(vif.busy), 8'h0);
        chk("game_sel", 8'(vif.screen_sel), 8'h1);
        chk("game_red", 8'(vif.red), 8'hF);
        chk("game_blue", 8'(vif.blue), 8'hC);

        // Game over with start_req asserted together
        vif.game_over = 1'b1;
        vif.start_req = 1'b1;
        tick();
        vif.game_over = 1'b0;
        vif.start_req = 1'b0;
        chk("go_busy", 8'(vif.busy), 8'h1);
        frames(4);
        vif.start_req = 1'b1;
        vif.game_over = 1'b1;
        tick();
        vif.start_req = 1'b0;
        vif.game_over = 1'b0;
        chk("go_ign_busy", 8'(vif.busy), 8'h1);
        frames(13);
        chk("go_l0_sel", 8'(vif.screen_sel), 8'h1);
        vif.game_over = 1'b1;
        tick();
        tick();
        vif.game_over = 1'b0;
        chk("go_midframe_sel", 8'(vif.screen_sel), 8'h1);
        vif.DrawX = 10'd0;
        vif.DrawY = 10'd480;
        tick();
        chk("go_pretick_sel", 8'(vif.screen_sel), 8'h1);
        vif.DrawX = 10'd1;
        vif.DrawY = 10'd0;
        tick();
        chk("go_tick_sel", 8'(vif.screen_sel), 8'h2);
        tick();
        tick();
        frames(16);
        chk("over_busy", 8'(vif.busy), 8'h0);
        chk("over_sel", 8'(vif.screen_sel), 8'h2);
        chk("over_red", 8'(vif.red), 8'h9);
        chk("over_blue", 8'(vif.blue), 8'hA);

        // Held tick position gives one tick
        vif.DrawX = 10'd0;
        vif.DrawY = 10'd480;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_ticks += int'(dut.r_frame_tick);
        end
        vif.DrawX = 10'd1;
        vif.DrawY = 10'd0;
        tick();
        n_ticks += int'(dut.r_frame_tick);
        tick();
        n_ticks += int'(dut.r_frame_tick);
        chk("hold_ticks", 8'(n_ticks), 8'h1);

        // Restart, then reset in FADE_IN at level 6
        vif.start_req = 1'b1;
        tick();
        vif.start_req = 1'b0;
        frames(18);
        chk("rs_swap_sel", 8'(vif.screen_sel), 8'h0);
        frames(6);
        chk("rs_l6_red", 8'(vif.red), 8'h5);
        chk("rs_l6_green", 8'(vif.green), 8'h3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_red", 8'(vif.red), 8'h0);
        chk("mid_rst_busy", 8'(vif.busy), 8'h0);
        chk("mid_rst_sel", 8'(vif.screen_sel), 8'h0);
        chk("mid_rst_level", 8'(dut.r_level), 8'h10);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_red", 8'(vif.red), 8'hF);
        chk("post_rst_green", 8'(vif.green), 8'h8);
        chk("post_rst_blue", 8'(vif.blue), 8'h1);
        chk("post_rst_busy", 8'(vif.busy), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
